// File: rtl/cru_pkg.sv
// Shared constants, FSM state type and the CRU address decode helper for cru_ctrl.
package cru_pkg;

    localparam logic [3:0] CRU_SPACE       = 4'b0001;
    localparam int         DEF_NBITS       = 4;
    localparam int         DEF_SYNC_STAGES = 2;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_PI_ACK = 1'b1
    } cru_state_e;

    // TI numbering: addr[0] is the MSB; addr[8:14] is the bit index within the card.
    function automatic logic cru_hit(input logic [0:14] a, input logic [3:0] base,
                                     input logic [6:0] nbits);
        return (a[0:3] == CRU_SPACE) && (a[4:7] == base) && (a[8:14] < nbits);
    endfunction

endpackage

// File: rtl/cru_ctrl_sync.sv
// Brings the asynchronous TI cru_clk strobe into the clk domain and emits a one-cycle
// write event together with the address/data that were sampled when the strobe first went low.
module cru_sync
    import cru_pkg::*;
#(
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cru_clk_i,
    input  logic [0:14] addr_i,
    input  logic        data_i,
    output logic        wr_ev_o,
    output logic [0:14] addr_o,
    output logic        data_o
);

    // sync_q[0] is the first sample; the extra top flop gives the previous synchronized level.
    logic [SYNC_STAGES:0]   sync_q;
    logic [0:14]            addr_dl_q [SYNC_STAGES];
    logic [SYNC_STAGES-1:0] data_dl_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q    <= '1;
            data_dl_q <= '0;
            for (int i = 0; i < SYNC_STAGES; i++) begin
                addr_dl_q[i] <= '0;
            end
        end else begin
            sync_q       <= {sync_q[SYNC_STAGES-1:0], cru_clk_i};
            data_dl_q    <= {data_dl_q[SYNC_STAGES-2:0], data_i};
            addr_dl_q[0] <= addr_i;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                addr_dl_q[i] <= addr_dl_q[i-1];
            end
        end
    end

    assign wr_ev_o = sync_q[SYNC_STAGES] & ~sync_q[SYNC_STAGES-1];
    assign addr_o  = addr_dl_q[SYNC_STAGES-1];
    assign data_o  = data_dl_q[SYNC_STAGES-1];

endmodule

// File: rtl/cru_ctrl.sv
// CRU output bit register shared between TI bus writes (fixed priority) and a local
// four-phase req/ack writer, with registered TI read-back.
module cru_ctrl
    import cru_pkg::*;
#(
    parameter int NBITS       = DEF_NBITS,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [3:0]               cru_base,
    input  logic                     cru_clk,
    input  logic [0:14]              addr,
    input  logic                     ti_cru_out,
    output logic                     ti_cru_in,
    output logic                     ti_cru_in_oe,
    input  logic                     pi_req,
    input  logic [$clog2(NBITS)-1:0] pi_idx,
    input  logic                     pi_val,
    output logic                     pi_ack,
    output logic [0:NBITS-1]         bits,
    output logic                     bits_chg
);

    localparam int         IW  = $clog2(NBITS);
    localparam logic [6:0] NB7 = 7'(NBITS);

    logic        ti_ev;
    logic [0:14] ti_addr;
    logic        ti_data;
    logic        ti_wr;
    logic [6:0]  ti_idx7;
    logic [6:0]  rd_idx7;
    logic        rd_hit;

    cru_state_e       state_q;
    logic [0:NBITS-1] bits_q, bits_d, bits_prev_q;
    logic             pi_ack_q, chg_q, rb_in_q, rb_oe_q;

    cru_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk       (clk),
        .rst_n     (rst_n),
        .cru_clk_i (cru_clk),
        .addr_i    (addr),
        .data_i    (ti_cru_out),
        .wr_ev_o   (ti_ev),
        .addr_o    (ti_addr),
        .data_o    (ti_data)
    );

    assign ti_wr   = ti_ev & cru_hit(ti_addr, cru_base, NB7);
    assign ti_idx7 = ti_addr[8:14];
    assign rd_idx7 = addr[8:14];
    assign rd_hit  = cru_hit(addr, cru_base, NB7);

    // A TI write always wins; the local request simply stays pending one more cycle.
    always_comb begin
        bits_d = bits_q;
        if (ti_wr) begin
            bits_d[ti_idx7[IW-1:0]] = ti_data;
        end else if (state_q == ST_IDLE && pi_req) begin
            bits_d[pi_idx] = pi_val;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            bits_q      <= '0;
            bits_prev_q <= '0;
            pi_ack_q    <= 1'b0;
            chg_q       <= 1'b0;
            rb_in_q     <= 1'b0;
            rb_oe_q     <= 1'b0;
        end else begin
            bits_q      <= bits_d;
            bits_prev_q <= bits_q;
            chg_q       <= (bits_q != bits_prev_q);
            rb_oe_q     <= rd_hit;
            rb_in_q     <= rd_hit ? bits_q[rd_idx7[IW-1:0]] : 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (pi_req && !ti_wr) begin
                        state_q  <= ST_PI_ACK;
                        pi_ack_q <= 1'b1;
                    end
                end
                ST_PI_ACK: begin
                    if (!pi_req) begin
                        state_q  <= ST_IDLE;
                        pi_ack_q <= 1'b0;
                    end
                end
                default: begin
                    state_q  <= ST_IDLE;
                    pi_ack_q <= 1'b0;
                end
            endcase
        end
    end

    assign bits         = bits_q;
    assign bits_chg     = chg_q;
    assign pi_ack       = pi_ack_q;
    assign ti_cru_in    = rb_in_q;
    assign ti_cru_in_oe = rb_oe_q;

endmodule
